mmio_responder: RTL and testbench

Memory-mapped I/O responder on the processor's data bus: decodes load/store requests addressed to the KEY, SW, HEX, LEDR and LEDG locations and completes each one with a single-cycle acknowledge. Owns the HEX/LEDR/LEDG output registers. Synchronizes and debounces the raw board KEY and SW inputs, and captures KEY press events in sticky flags. Sits between the datapath's load/store path and the board pins; the top level feeds `hex_value` into the six SevenSeg instances.

---
 rtl/mmio_responder_if.sv | 22 ++
 rtl/mmio_responder.sv | 141 ++++++++++++++
 tb/tb_mmio_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_responder_if.sv
// Load/store bus between the datapath and mmio_responder.
// The datapath drives the request side and the responder returns the single-cycle ack.
interface mmio_responder_if #(
    parameter int unsigned DBITS = 32
);
    logic             bus_req;
    logic             bus_we;
    logic [DBITS-1:0] bus_addr;
    logic [DBITS-1:0] bus_wdata;
    logic [DBITS-1:0] bus_rdata;
    logic             bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder for the KEY/SW/HEX/LEDR/LEDG registers, with a single-cycle acknowledge.
// Define MMIO_DEBOUNCE_EN to add per-bit debounce counters on the synchronized KEY/SW inputs.
module mmio_responder #(
    parameter int unsigned      DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter int unsigned      DEBOUNCE_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mmio_responder_if.slave        dbus,
    input  logic [3:0]             KEY,
    input  logic [9:0]             SW,
    output logic [23:0]            hex_value,
    output logic [9:0]             ledr,
    output logic [7:0]             ledg
);
    localparam int unsigned NIN = 14;

    logic [3:0]     key_s1, key_s2;
    logic [9:0]     sw_s1, sw_s2;
    logic [NIN-1:0] in_sample;
    logic [NIN-1:0] in_state;
    logic [NIN-1:0] in_state_nxt;
    logic [3:0]     key_state, key_rise, key_clr;
    logic [9:0]     sw_state;
    logic [3:0]     press_flags;
    logic           accept, store;
    logic [DBITS-1:0] rd_data;
    logic           unused_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // Keys are inverted here so every input bit reads 1 = active.
    assign in_sample = {sw_s2, ~key_s2};

`ifdef MMIO_DEBOUNCE_EN
    localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt     [NIN];
    logic [CW-1:0] cnt_nxt [NIN];

    always_comb begin
        in_state_nxt = in_state;
        for (int unsigned i = 0; i < NIN; i++) begin
            cnt_nxt[i] = '0;
            if (in_sample[i] != in_state[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    in_state_nxt[i] = in_sample[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_state <= '0;
            for (int unsigned i = 0; i < NIN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            in_state <= in_state_nxt;
            cnt      <= cnt_nxt;
        end
    end
`else
    // Without debounce the state is the second sync flop itself; next value is the first flop.
    logic unused_deb;
    assign unused_deb   = DEBOUNCE_CYCLES[0];
    assign in_state     = in_sample;
    assign in_state_nxt = {sw_s1, ~key_s1};
`endif

    assign key_state = in_state[3:0];
    assign sw_state  = in_state[13:4];
    assign key_rise  = in_state_nxt[3:0] & ~in_state[3:0];

    assign accept  = dbus.bus_req && !dbus.bus_ack;
    assign store   = accept && dbus.bus_we;
    assign key_clr = (store && dbus.bus_addr == ADDR_KEY) ? dbus.bus_wdata[7:4] : '0;

    always_comb begin
        rd_data = '0;
        if (dbus.bus_addr == ADDR_HEX) begin
            rd_data = DBITS'(hex_value);
        end else if (dbus.bus_addr == ADDR_LEDR) begin
            rd_data = DBITS'(ledr);
        end else if (dbus.bus_addr == ADDR_LEDG) begin
            rd_data = DBITS'(ledg);
        end else if (dbus.bus_addr == ADDR_KEY) begin
            rd_data = DBITS'({press_flags, key_state});
        end else if (dbus.bus_addr == ADDR_SW) begin
            rd_data = DBITS'(sw_state);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbus.bus_ack   <= 1'b0;
            dbus.bus_rdata <= '0;
        end else begin
            dbus.bus_ack   <= accept;
            dbus.bus_rdata <= accept ? rd_data : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_value   <= '0;
            ledr        <= '0;
            ledg        <= '0;
            press_flags <= '0;
        end else begin
            if (store && dbus.bus_addr == ADDR_HEX) hex_value <= dbus.bus_wdata[23:0];
            if (store && dbus.bus_addr == ADDR_LEDR) ledr <= dbus.bus_wdata[9:0];
            if (store && dbus.bus_addr == ADDR_LEDG) ledg <= dbus.bus_wdata[7:0];
            // A new press in the same cycle as a clear keeps the flag set.
            press_flags <= (press_flags & ~key_clr) | key_rise;
        end
    end

    assign unused_ok = ^dbus.bus_wdata[DBITS-1:24];
endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: a reference model queues expected load data,
// a monitor compares on every ack and checks the output registers each cycle.
module tb_mmio_responder;
    localparam int unsigned DBITS = 32;
    localparam int unsigned DEB   = 8;
    localparam logic [31:0] A_HEX  = 32'hF0000000;
    localparam logic [31:0] A_LEDR = 32'hF0000004;
    localparam logic [31:0] A_LEDG = 32'hF0000008;
    localparam logic [31:0] A_KEY  = 32'hF0000010;
    localparam logic [31:0] A_SW   = 32'hF0000014;
    localparam logic [31:0] A_BAD  = 32'hF000000C;
`ifdef MMIO_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic [23:0] hex_value;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    mmio_responder_if #(.DBITS(DBITS)) dbus ();

    mmio_responder #(
        .DBITS(DBITS), .ADDR_HEX(A_HEX), .ADDR_LEDR(A_LEDR), .ADDR_LEDG(A_LEDG),
        .ADDR_KEY(A_KEY), .ADDR_SW(A_SW), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dbus(dbus), .KEY(KEY), .SW(SW),
        .hex_value(hex_value), .ledr(ledr), .ledg(ledg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers, raw-input delay line, debounced view, press flags.
    logic [23:0] m_hex = '0;
    logic [9:0]  m_ledr = '0, m_sw = '0;
    logic [7:0]  m_ledg = '0;
    logic [3:0]  m_flags = '0, m_key = '0;
    logic [3:0]  key_d1 = 4'hF, key_d2 = 4'hF;
    logic [9:0]  sw_d1 = '0, sw_d2 = '0;
    int          run [14];
    bit          m_ack = 1'b0;
    logic [31:0] exp_q [$];

    always @(posedge clk or negedge reset_n) begin
        logic [31:0] rd;
        logic [13:0] samp, st_new;
        logic [3:0]  clr;
        bit          acc;
        if (!reset_n) begin
            m_hex = '0; m_ledr = '0; m_ledg = '0; m_flags = '0; m_key = '0; m_sw = '0;
            key_d1 = 4'hF; key_d2 = 4'hF; sw_d1 = '0; sw_d2 = '0;
            foreach (run[i]) run[i] = 0;
            m_ack = 1'b0;
            exp_q.delete();
        end else begin
            acc = dbus.bus_req && !m_ack;
            clr = '0;
            if (acc) begin
                case (dbus.bus_addr)
                    A_HEX:   rd = {8'h0, m_hex};
                    A_LEDR:  rd = {22'h0, m_ledr};
                    A_LEDG:  rd = {24'h0, m_ledg};
                    A_KEY:   rd = {24'h0, m_flags, m_key};
                    A_SW:    rd = {22'h0, m_sw};
                    default: rd = '0;
                endcase
                exp_q.push_back(rd);
                if (dbus.bus_we) begin
                    case (dbus.bus_addr)
                        A_HEX:   m_hex  = dbus.bus_wdata[23:0];
                        A_LEDR:  m_ledr = dbus.bus_wdata[9:0];
                        A_LEDG:  m_ledg = dbus.bus_wdata[7:0];
                        A_KEY:   clr    = dbus.bus_wdata[7:4];
                        default: ;
                    endcase
                end
            end
            m_ack = acc;
            // Raw level seen two edges ago is what the debounce logic judges now.
            samp = {sw_d2, ~key_d2};
            st_new = {m_sw, m_key};
            if (DEB_EN) begin
                for (int i = 0; i < 14; i++) begin
                    if (samp[i] != st_new[i]) begin
                        run[i]++;
                        if (run[i] == DEB) begin
                            st_new[i] = samp[i];
                            run[i] = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
            end else begin
                st_new = {sw_d1, ~key_d1};
            end
            key_d2 = key_d1; key_d1 = KEY;
            sw_d2 = sw_d1;   sw_d1 = SW;
            m_flags = (m_flags & ~clr) | (st_new[3:0] & ~m_key);
            m_key = st_new[3:0];
            m_sw  = st_new[13:4];
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("ack", {31'h0, dbus.bus_ack}, {31'h0, m_ack});
            if (dbus.bus_ack) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got ack with no expected response at %0t", $time);
                end else begin
                    check("rdata", dbus.bus_rdata, exp_q.pop_front());
                end
            end else begin
                check("rdata_idle", dbus.bus_rdata, 32'h0);
            end
            check("hex_value", {8'h0, hex_value}, {8'h0, m_hex});
            check("ledr", {22'h0, ledr}, {22'h0, m_ledr});
            check("ledg", {24'h0, ledg}, {24'h0, m_ledg});
        end
    end

    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd);
        int n;
        @(negedge clk);
        dbus.bus_req = 1'b1; dbus.bus_we = we; dbus.bus_addr = addr; dbus.bus_wdata = wdata;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!dbus.bus_ack && n < 8);
        rd = dbus.bus_rdata;
        if (!dbus.bus_ack) begin
            checks++; errors++;
            $display("FAIL txn_timeout: got no ack expected ack within 8 cycles addr %h", addr);
        end
        @(negedge clk);
        dbus.bus_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] addrs [6];
        bit          done;
        addrs[0] = A_HEX; addrs[1] = A_LEDR; addrs[2] = A_LEDG;
        addrs[3] = A_KEY; addrs[4] = A_SW;   addrs[5] = A_BAD;
        dbus.bus_req = 1'b0; dbus.bus_we = 1'b0; dbus.bus_addr = '0; dbus.bus_wdata = '0;

        repeat (3) @(negedge clk);
        check("reset_ack", {31'h0, dbus.bus_ack}, 32'h0);
        check("reset_rdata", dbus.bus_rdata, 32'h0);
        check("reset_outs", {hex_value, ledr[7:0]}, 32'h0);
        reset_n = 1'b1;

        txn(0, A_HEX, '0, rd);  check("load_hex_reset", rd, 32'h0);
        txn(0, A_LEDR, '0, rd); check("load_ledr_reset", rd, 32'h0);
        txn(0, A_LEDG, '0, rd); check("load_ledg_reset", rd, 32'h0);
        txn(0, A_SW, '0, rd);   check("load_sw_reset", rd, 32'h0);

        txn(1, A_HEX, 32'h00ABCDEF, rd); check("hex_after_store", {8'h0, hex_value}, 32'h00ABCDEF);
        txn(0, A_HEX, '0, rd);           check("load_hex", rd, 32'h00ABCDEF);
        txn(1, A_LEDR, 32'hFFFFFFFF, rd); check("ledr_after_store", {22'h0, ledr}, 32'h3FF);
        txn(1, A_LEDG, 32'h000001A5, rd); check("ledg_after_store", {24'h0, ledg}, 32'hA5);
        txn(1, A_BAD, 32'h1234, rd);
        check("unmapped_no_change", {hex_value, ledg}, 32'hABCDEFA5);
        txn(0, A_BAD, '0, rd);           check("load_unmapped", rd, 32'h0);

        @(negedge clk); KEY = 4'b1011;
        repeat (DEB_EN ? 12 : 4) @(negedge clk);
        txn(0, A_KEY, '0, rd);           check("key_press", rd, 32'h44);
        txn(1, A_KEY, 32'h40, rd);
        txn(0, A_KEY, '0, rd);           check("key_flag_clear", rd, 32'h04);
        KEY = 4'hF;
        repeat (DEB_EN ? 12 : 4) @(negedge clk);
        txn(0, A_KEY, '0, rd);           check("key_release", rd, 32'h0);

        // Bouncing switch while SW loads run back-to-back.
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk); SW[0] = ~SW[0];
                    repeat (3) @(negedge clk);
                end
                @(negedge clk); SW[0] = 1'b1;
            end
            begin
                @(negedge clk);
                dbus.bus_req = 1'b1; dbus.bus_we = 1'b0; dbus.bus_addr = A_SW;
                repeat (60) @(negedge clk);
                dbus.bus_req = 1'b0;
            end
        join
        repeat (12) @(negedge clk);
        txn(0, A_SW, '0, rd);            check("sw_settled", rd, 32'h1);

        @(negedge clk);
        dbus.bus_req = 1'b1; dbus.bus_we = 1'b0; dbus.bus_addr = A_LEDG;
        check("b2b_ack0", {31'h0, dbus.bus_ack}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("b2b_ack", {31'h0, dbus.bus_ack}, (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        dbus.bus_req = 1'b0;

        done = 1'b0;
        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    if ($urandom_range(0, 9) == 0) KEY = KEY ^ (4'h1 << $urandom_range(0, 3));
                    if ($urandom_range(0, 9) == 0) SW = SW ^ (10'h1 << $urandom_range(0, 9));
                end
            end
            begin
                for (int t = 0; t < 250; t++) begin
                    logic [31:0] a;
                    a = ($urandom_range(0, 15) == 0) ? $urandom : addrs[$urandom_range(0, 5)];
                    txn($urandom_range(0, 2) == 0, a, $urandom, rd);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                done = 1'b1;
            end
        join

        txn(1, A_LEDR, 32'h155, rd);
        @(negedge clk);
        dbus.bus_req = 1'b1; dbus.bus_we = 1'b1; dbus.bus_addr = A_HEX; dbus.bus_wdata = 32'h123456;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("rst_ack", {31'h0, dbus.bus_ack}, 32'h0);
        check("rst_rdata", dbus.bus_rdata, 32'h0);
        check("rst_hex", {8'h0, hex_value}, 32'h0);
        check("rst_leds", {14'h0, ledr, ledg}, 32'h0);
        dbus.bus_req = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        txn(0, A_LEDR, '0, rd);          check("load_after_reset", rd, 32'h0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
